pc_ctrl: RTL and testbench
==========================

PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, PC value loaded on reset.
REQ-002 Parameter EXC_VECTOR, default 32'h0000_4180, PC value loaded on exception entry.
REQ-003 Parameter PC_W, default 32, PC/target width (range 32..64; upper bits beyond 32 zero-extend all 32-bit inputs).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 stall  input  1  hold F-stage PC this cycle.
REQ-007 npc_op  input  4  control-flow op of the D-stage instruction.
REQ-008 pc_d  input  PC_W  PC of the D-stage instruction.
REQ-009 imm16  input  16  branch offset; imm26  input  26  jump index.
REQ-010 rs_val, rt_val  input  32  forwarded operands for compare/jr.
REQ-011 exc_req  input  1  exception entry; eret_req  input  1  return; epc  input  PC_W  return target.
REQ-012 pc  output  PC_W  current F-stage PC (registered).
REQ-013 redirect  output  1  D-stage op resolves taken this cycle (combinational).
REQ-014 pending  output  1  registered taken target awaiting stall release.
REQ-015 adel  output  1  pc[1:0] != 0 (combinational from pc).

Function
REQ-016 npc_op encodings SHALL be: 0 seq, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz, 6 bgez, 7 j/jal, 8 jr/jalr; 9..15 treated as seq.
REQ-017 Branch conditions SHALL use signed 32-bit compare: beq rs==rt, bne rs!=rt, blez rs<=0, bgtz rs>0, bltz rs<0, bgez rs>=0.
REQ-018 Branch target SHALL be pc_d + 4 + (sext(imm16) << 2), modulo 2^PC_W.
REQ-019 Jump target SHALL be {pc_d[PC_W-1:28], imm26, 2'b00}; jr target SHALL be rs_val unmodified (no alignment fix-up).
REQ-020 redirect SHALL be 1 when op 7/8, or op 1..6 with condition true; independent of stall.
REQ-021 Next-PC priority per edge SHALL be: reset > exc_req > eret_req > stall > pending > redirect > pc+4.
REQ-022 Not-taken branch and seq SHALL load pc+4 (delay slot already fetched); pc+4 SHALL wrap from all-ones-minus-3 to 0.
REQ-023 Redirect while stall=1 SHALL capture target into pending register, set pending=1, hold pc.
REQ-024 Redirect while pending=1 and stall=1 SHALL overwrite the captured target (latest wins).
REQ-025 First edge with stall=0 and pending=1 SHALL load pc <= pending target and clear pending, ignoring redirect that cycle.
REQ-026 exc_req SHALL load EXC_VECTOR, eret_req SHALL load epc, both regardless of stall, both clearing pending.
REQ-027 exc_req and eret_req together SHALL take exc_req.
REQ-028 Latency: redirect with stall=0 SHALL appear on pc one edge later; stalled redirect on the edge stall drops.
REQ-029 adel SHALL not alter PC sequencing; misaligned pc advances by 4 normally.

Reset
REQ-030 On reset edge: pc=RESET_PC, pending=0, stored target=0; reset mid-stall or mid-pending SHALL discard pending.
REQ-031 Outputs after reset: pc=RESET_PC, pending=0, adel=0 (RESET_PC aligned), redirect per current inputs.

Verification
REQ-032 Reset then 3 edges, npc_op=0, stall=0 -> pc 0x3000, 0x3004, 0x3008, 0x300C.
REQ-033 pc_d=0x3004, npc_op=1, rs=rt=5, imm16=0xFFFF -> redirect=1, next pc=0x3004.
REQ-034 bgtz with rs=0x8000_0000 -> redirect=0, pc=pc+4; bltz same rs -> redirect=1.
REQ-035 jr rs_val=0x3100 with stall=1 for 2 cycles -> pc held, pending=1; stall drops -> pc=0x3100, pending=0.
REQ-036 Pending set, exc_req=1 and eret_req=1 same edge -> pc=0x4180, pending=0; later eret_req, epc=0x3010 -> pc=0x3010.
REQ-037 jr rs_val=0x3102 -> pc=0x3102, adel=1; next edge seq -> pc=0x3106; PC_W=32 from 0xFFFF_FFFC seq -> pc=0.

Source files
------------

// File: rtl/pc_ctrl.sv
// Purpose : fetch-stage program counter with branch/jump resolution, stall capture and exception/eret entry.
// Latency : redirect takes effect on pc one edge later; a redirect seen under stall lands on the edge stall drops.
// Backpr. : stall holds pc; a taken target during stall is parked in a pending register (latest wins).
//
// Ports:
//   clk, reset           - single clock, synchronous active-high reset
//   stall                - hold the F-stage PC this cycle
//   npc_op               - D-stage control-flow op (0 seq,1 beq,2 bne,3 blez,4 bgtz,5 bltz,6 bgez,7 j,8 jr)
//   pc_d, imm16, imm26   - D-stage PC and branch offset / jump index
//   rs_val, rt_val       - forwarded operands for compares and jr
//   exc_req, eret_req    - exception entry / return; epc is the return target
//   pc, pending          - registered F-stage PC and parked-target flag
//   redirect, adel       - combinational taken flag and PC misalignment flag
module pc_ctrl #(
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] RESET_PC   = PC_W'(32'h0000_3000),
    parameter logic [PC_W-1:0] EXC_VECTOR = PC_W'(32'h0000_4180)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic [3:0]      npc_op,
    input  logic [PC_W-1:0] pc_d,
    input  logic [15:0]     imm16,
    input  logic [25:0]     imm26,
    input  logic [31:0]     rs_val,
    input  logic [31:0]     rt_val,
    input  logic            exc_req,
    input  logic            eret_req,
    input  logic [PC_W-1:0] epc,
    output logic [PC_W-1:0] pc,
    output logic            redirect,
    output logic            pending,
    output logic            adel
);

    localparam logic [3:0] OP_BEQ  = 4'd1;
    localparam logic [3:0] OP_BNE  = 4'd2;
    localparam logic [3:0] OP_BLEZ = 4'd3;
    localparam logic [3:0] OP_BGTZ = 4'd4;
    localparam logic [3:0] OP_BLTZ = 4'd5;
    localparam logic [3:0] OP_BGEZ = 4'd6;
    localparam logic [3:0] OP_J    = 4'd7;
    localparam logic [3:0] OP_JR   = 4'd8;

    logic [PC_W-1:0] pc_q;
    logic            pending_q;
    logic [PC_W-1:0] tgt_q;

    logic [PC_W-1:0] br_tgt;
    logic [PC_W-1:0] j_tgt;
    logic [PC_W-1:0] jr_tgt;
    logic [PC_W-1:0] redir_tgt;
    logic            taken;
    logic signed [31:0] rs_s;
    logic signed [31:0] rt_s;

    assign rs_s = rs_val;
    assign rt_s = rt_val;

    // Offset is sign-extended to the full PC width so the add wraps modulo 2^PC_W.
    assign br_tgt = pc_d + PC_W'(4) + {{(PC_W-18){imm16[15]}}, imm16, 2'b00};
    assign j_tgt  = {pc_d[PC_W-1:28], imm26, 2'b00};
    assign jr_tgt = PC_W'(rs_val);

    always_comb begin
        taken     = 1'b0;
        redir_tgt = br_tgt;
        case (npc_op)
            OP_BEQ:  taken = (rs_s == rt_s);
            OP_BNE:  taken = (rs_s != rt_s);
            OP_BLEZ: taken = (rs_s <= 32'sd0);
            OP_BGTZ: taken = (rs_s >  32'sd0);
            OP_BLTZ: taken = (rs_s <  32'sd0);
            OP_BGEZ: taken = (rs_s >= 32'sd0);
            OP_J: begin
                taken     = 1'b1;
                redir_tgt = j_tgt;
            end
            OP_JR: begin
                taken     = 1'b1;
                redir_tgt = jr_tgt;
            end
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            pending_q <= 1'b0;
            tgt_q     <= '0;
        end else if (exc_req) begin
            pc_q      <= EXC_VECTOR;
            pending_q <= 1'b0;
        end else if (eret_req) begin
            pc_q      <= epc;
            pending_q <= 1'b0;
        end else if (stall) begin
            // Park the target; a later redirect in the same stall overwrites it.
            if (taken) begin
                pending_q <= 1'b1;
                tgt_q     <= redir_tgt;
            end
        end else if (pending_q) begin
            // Parked target wins over whatever the D stage shows now.
            pc_q      <= tgt_q;
            pending_q <= 1'b0;
        end else if (taken) begin
            pc_q <= redir_tgt;
        end else begin
            pc_q <= pc_q + PC_W'(4);
        end
    end

    assign pc       = pc_q;
    assign pending  = pending_q;
    assign redirect = taken;
    assign adel     = (pc_q[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_ctrl.sv
module tb_pc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [3:0]  npc_op;
    logic [31:0] pc_d;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic [31:0] pc;
    logic        redirect;
    logic        pending;
    logic        adel;

    int total  = 0;
    int passed = 0;

    pc_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .npc_op   (npc_op),
        .pc_d     (pc_d),
        .imm16    (imm16),
        .imm26    (imm26),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .exc_req  (exc_req),
        .eret_req (eret_req),
        .epc      (epc),
        .pc       (pc),
        .redirect (redirect),
        .pending  (pending),
        .adel     (adel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // One rising edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; npc_op = 4'd0; pc_d = 32'h0; imm16 = 16'h0;
        imm26 = 26'h0; rs_val = 32'h0; rt_val = 32'h0; exc_req = 1'b0;
        eret_req = 1'b0; epc = 32'h0;

        // Reset state
        step();
        check("rst_pc", pc, 32'h0000_3000);
        check("rst_pending", {31'b0, pending}, 32'd0);
        check("rst_adel", {31'b0, adel}, 32'd0);
        reset = 1'b0;

        // Sequential fetch
        step(); check("seq1", pc, 32'h0000_3004);
        step(); check("seq2", pc, 32'h0000_3008);
        step(); check("seq3", pc, 32'h0000_300C);

        // beq taken, backward offset -1 word: 0x3004+4-4
        pc_d = 32'h0000_3004; npc_op = 4'd1; rs_val = 32'd5; rt_val = 32'd5; imm16 = 16'hFFFF;
        #1 check("beq_redir", {31'b0, redirect}, 32'd1);
        step(); check("beq_pc", pc, 32'h0000_3004);

        // Other compare conditions, combinational only
        npc_op = 4'd2; #1 check("bne_eq_redir", {31'b0, redirect}, 32'd0);
        npc_op = 4'd3; rs_val = 32'd0; #1 check("blez_zero_redir", {31'b0, redirect}, 32'd1);
        npc_op = 4'd6; rs_val = 32'h8000_0000; #1 check("bgez_neg_redir", {31'b0, redirect}, 32'd0);
        npc_op = 4'd9; rs_val = 32'd0; #1 check("op9_redir", {31'b0, redirect}, 32'd0);

        // bgtz on most-negative value: not taken, pc+4
        npc_op = 4'd4; rs_val = 32'h8000_0000;
        #1 check("bgtz_redir", {31'b0, redirect}, 32'd0);
        step(); check("bgtz_pc", pc, 32'h0000_3008);

        // bltz same operand: taken, 0x3004+4+0x40
        npc_op = 4'd5; imm16 = 16'h0010;
        #1 check("bltz_redir", {31'b0, redirect}, 32'd1);
        step(); check("bltz_pc", pc, 32'h0000_3048);

        // jr under 2-cycle stall; second stalled redirect overwrites the first
        npc_op = 4'd8; rs_val = 32'h0000_2F00; stall = 1'b1;
        #1 check("jr_stall_redir", {31'b0, redirect}, 32'd1);
        step();
        check("stall1_pc", pc, 32'h0000_3048);
        check("stall1_pending", {31'b0, pending}, 32'd1);
        rs_val = 32'h0000_3100;
        step();
        check("stall2_pc", pc, 32'h0000_3048);
        check("stall2_pending", {31'b0, pending}, 32'd1);
        // Stall drops with a fresh redirect present: parked target wins
        stall = 1'b0; rs_val = 32'h0000_5000;
        step();
        check("release_pc", pc, 32'h0000_3100);
        check("release_pending", {31'b0, pending}, 32'd0);
        npc_op = 4'd0;
        step(); check("after_release_pc", pc, 32'h0000_3104);

        // Pending set, then exc+eret together: exception wins and clears pending
        npc_op = 4'd8; rs_val = 32'h0000_6000; stall = 1'b1;
        step(); check("exc_pre_pending", {31'b0, pending}, 32'd1);
        exc_req = 1'b1; eret_req = 1'b1; epc = 32'h0000_3010;
        step();
        check("exc_pc", pc, 32'h0000_4180);
        check("exc_pending", {31'b0, pending}, 32'd0);
        exc_req = 1'b0; stall = 1'b0; npc_op = 4'd0;
        step(); check("eret_pc", pc, 32'h0000_3010);
        eret_req = 1'b0;

        // Misaligned jr target: adel set, sequencing unaffected
        npc_op = 4'd8; rs_val = 32'h0000_3102;
        step();
        check("mis_pc", pc, 32'h0000_3102);
        check("mis_adel", {31'b0, adel}, 32'd1);
        npc_op = 4'd0;
        step(); check("mis_seq_pc", pc, 32'h0000_3106);

        // Wrap from top of address space
        npc_op = 4'd8; rs_val = 32'hFFFF_FFFC;
        step(); check("top_pc", pc, 32'hFFFF_FFFC);
        npc_op = 4'd0;
        step(); check("wrap_pc", pc, 32'h0000_0000);

        // j: {pc_d[31:28], imm26, 00}
        npc_op = 4'd7; pc_d = 32'hA000_1234; imm26 = 26'h000_0123;
        step(); check("j_pc", pc, 32'hA000_048C);

        // Reset during pending discards the parked target
        npc_op = 4'd8; rs_val = 32'h0000_7000; stall = 1'b1;
        step(); check("rstp_pending", {31'b0, pending}, 32'd1);
        reset = 1'b1;
        step();
        check("rstp_pc", pc, 32'h0000_3000);
        check("rstp_pend_clr", {31'b0, pending}, 32'd0);
        reset = 1'b0; stall = 1'b0; npc_op = 4'd0;
        step(); check("rstp_seq_pc", pc, 32'h0000_3004);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
